inst_encode_loader: RTL and testbench
=====================================

INST_ENCODE_LOADER -- requirements
Module: inst_encode_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 12, giving the instruction-memory address width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset (one clock; reset asynchronous and active-low).
REQ-005 SHALL have port in_valid, input, 1 bit: the field bundle is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a bundle.
REQ-007 SHALL have port fmt, input, 2 bits: 0=R, 1=I, 2=JI, 3=JII.
REQ-008 SHALL have ports opcode, rd, rs, rt, shamt and aluop, each input, 5 bits: instruction fields.
REQ-009 SHALL have port immed, input, 17 bits, and port target, input, 27 bits.
REQ-010 SHALL have port addr_load, input, 1 bit (load request), and port addr_in, input, ADDR_W bits (new write address).
REQ-011 SHALL have port mem_we, output, 1 bit, plus mem_addr (ADDR_W bits) and mem_data (32 bits): the write request to instruction memory.
REQ-012 SHALL have port mem_ready, input, 1 bit: memory accepts the write this cycle.
REQ-013 SHALL have port busy, output, 1 bit; wrapped, output, 1 bit (sticky); and written, output, 16 bits.

Function
REQ-014 SHALL encode the word as {opcode,rd,rs,rt,shamt,aluop,2'b00} when fmt=R.
REQ-015 SHALL encode the word as {opcode,rd,rs,immed} when fmt=I; rt, shamt, aluop and target are ignored.
REQ-016 SHALL encode the word as {opcode,target} when fmt=JI, and as {opcode,rd,22'b0} when fmt=JII.
REQ-017 SHALL accept a bundle only on an edge where in_valid and in_ready are both 1, pushing the encoded word into the FIFO.
REQ-018 SHALL drive in_ready = (FIFO count < DEPTH) from registered state only; a pop on the same edge does not enable a push while full.
REQ-019 SHALL model the output stage as a 2-state machine: IDLE (mem_we=0) and WRITE (mem_we=1); a write is "taken" on an edge with mem_we and mem_ready both 1.
REQ-020 SHALL, from IDLE with the FIFO non-empty, pop the head into mem_data and go to WRITE on the next edge.
REQ-021 SHALL, in WRITE, hold mem_addr and mem_data stable until the write is taken.
REQ-022 SHALL, on a taken write, pop the next head and stay in WRITE if the FIFO is non-empty, else go to IDLE; back-to-back taken writes give one word per cycle.
REQ-023 SHALL give latency from an accept into an empty FIFO while IDLE to mem_we=1 of exactly 2 edges; a push and pop on the same edge are both honoured.
REQ-024 SHALL, on each taken write, increment mem_addr modulo 2^ADDR_W and saturating-increment written.
REQ-025 SHALL, when mem_addr wraps from all-ones to 0, set wrapped, which stays set until reset.
REQ-026 SHALL apply addr_load (mem_addr <= addr_in) only when IDLE with the FIFO empty; otherwise addr_load is ignored.
REQ-027 SHALL drive busy = (FIFO non-empty) OR (state == WRITE).

Reset
REQ-028 SHALL, while reset_n=0, asynchronously clear the FIFO pointers/count, state=IDLE, mem_we=0, mem_addr=0, mem_data=0, written=0 and wrapped=0; in_ready=1 once the FIFO is cleared.
REQ-029 SHALL, on reset asserted mid-write, drop the pending write with no memory write taken; reset release is synchronous to clock with no spurious mem_we.

Verification
REQ-030 SHALL cover R-type: opcode=0, rd=1, rs=2, rt=3, shamt=0, aluop=0 -> mem_data=0x00443000 at mem_addr=0, mem_we high 2 edges after accept.
REQ-031 SHALL cover I/JI/JII: I-type opcode=5, rd=1, rs=0, immed=0x1FFFF -> 0x2841FFFF; JI opcode=1, target=0x10 -> 0x08000010; JII opcode=4, rd=31 -> 0x27C00000; consecutive addresses 0,1,2.
REQ-032 SHALL cover backpressure: mem_ready=0 with 5 bundles offered -> 4 in FIFO + 1 in WRITE, in_ready=0; release mem_ready -> 5 writes on 5 consecutive edges, written=5.
REQ-033 SHALL cover wrap: addr_load with addr_in=0xFFF, then 2 writes -> addresses 0xFFF then 0x000, wrapped=1.
REQ-034 SHALL cover ignored load: addr_load while busy -> mem_addr sequence unchanged.
REQ-035 SHALL cover reset mid-WRITE (mem_ready=0) -> mem_we=0, written=0, FIFO empty, in_ready=1.

Source files
------------

// File: rtl/inst_encode_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them through a
// small FIFO into instruction memory at an auto-incrementing, loadable address.

module inst_encode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Storage is not reset: the count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rptr];

endmodule

module inst_encode_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [4:0]        aluop,
  input  logic [16:0]       immed,
  input  logic [26:0]       target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              wrapped,
  output logic [15:0]       written
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_JI  = 2'd2;
  localparam logic [1:0] FMT_JII = 2'd3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]       state;
  logic [31:0]      enc_word;
  logic [31:0]      head_dat;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             taken;

  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_R:   enc_word = {opcode, rd, rs, rt, shamt, aluop, 2'b00};
      FMT_I:   enc_word = {opcode, rd, rs, immed};
      FMT_JI:  enc_word = {opcode, target};
      FMT_JII: enc_word = {opcode, rd, 22'd0};
      default: enc_word = 32'd0;
    endcase
  end

  // Ready depends only on the registered count, so a same-edge pop never
  // opens a slot for a push while full.
  assign in_ready   = (count < FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign taken      = (state == WRITE) && mem_ready;
  assign pop        = !fifo_empty && ((state == IDLE) || taken);

  inst_encode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (enc_word),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      written  <= '0;
      wrapped  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mem_data <= head_dat;
            state    <= WRITE;
          end else if (addr_load) begin
            mem_addr <= addr_in;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_addr <= mem_addr + 1'b1;
            if (written != 16'hFFFF) written <= written + 16'd1;
            if (&mem_addr) wrapped <= 1'b1;
            if (!fifo_empty) mem_data <= head_dat;
            else             state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we = (state == WRITE);
  assign busy   = !fifo_empty || mem_we;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader: encodings, latency, backpressure,
// address load/wrap and reset during a pending write.

module tb_inst_encode_loader;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [16:0] immed;
  logic [26:0] target;
  logic        addr_load;
  logic [11:0] addr_in;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        busy;
  logic        wrapped;
  logic [15:0] written;

  int n_assert = 0;
  int n_fail   = 0;

  inst_encode_loader #(.DEPTH(4), .ADDR_W(12)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .shamt     (shamt),
    .aluop     (aluop),
    .immed     (immed),
    .target    (target),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .busy      (busy),
    .wrapped   (wrapped),
    .written   (written)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_bundle(input logic [1:0] f, input logic [4:0] op, input logic [4:0] rdv,
                            input logic [4:0] rsv, input logic [4:0] rtv, input logic [4:0] sh,
                            input logic [4:0] al, input logic [16:0] im, input logic [26:0] tg);
    fmt = f; opcode = op; rd = rdv; rs = rsv; rt = rtv;
    shamt = sh; aluop = al; immed = im; target = tg;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_in = '0; mem_ready = 1'b0;
    set_bundle(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_written",  32'(written),  32'd0);
    chk("rst_wrapped",  32'(wrapped),  32'd0);
    chk("rst_addr",     32'(mem_addr), 32'd0);
    chk("rst_data",     mem_data,      32'd0);
    #9 reset_n = 1'b1;
    tick();

    // R-type, mem_we exactly two edges after the accept
    set_bundle(2'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'h1ABCD, 27'h5555555);
    in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("r_we_edge1",  32'(mem_we), 32'd0);
    chk("r_busy",      32'(busy),   32'd1);
    tick();
    chk("r_we_edge2",  32'(mem_we),   32'd1);
    chk("r_data",      mem_data,      32'h00443000);
    chk("r_addr",      32'(mem_addr), 32'd0);
    tick();
    chk("r_done_we",   32'(mem_we),   32'd0);
    chk("r_written",   32'(written),  32'd1);
    chk("r_addr_inc",  32'(mem_addr), 32'd1);
    chk("r_idle_busy", 32'(busy),     32'd0);

    // I / JI / JII at consecutive addresses
    apply_reset();
    mem_ready = 1'b0;
    set_bundle(2'd1, 5'd5, 5'd1, 5'd0, 5'd7, 5'd9, 5'd3, 17'h1FFFF, 27'h7FFFFFF);
    in_valid = 1'b1;
    tick();
    set_bundle(2'd2, 5'd1, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'h1FFFF, 27'h0000010);
    tick();
    set_bundle(2'd3, 5'd4, 5'd31, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1FFFF, 27'h7FFFFFF);
    tick();
    in_valid = 1'b0;
    chk("i_we",     32'(mem_we),   32'd1);
    chk("i_data",   mem_data,      32'h2841FFFF);
    chk("i_addr",   32'(mem_addr), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("ji_data",  mem_data,      32'h08000010);
    chk("ji_addr",  32'(mem_addr), 32'd1);
    tick();
    chk("jii_data", mem_data,      32'h27C00000);
    chk("jii_addr", 32'(mem_addr), 32'd2);
    tick();
    chk("ij_idle",    32'(mem_we),  32'd0);
    chk("ij_written", 32'(written), 32'd3);

    // Backpressure: 4 in FIFO + 1 held in WRITE; a sixth offer must not slip in
    apply_reset();
    mem_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_bundle(2'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'(k + 1));
      tick();
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_we",       32'(mem_we),   32'd1);
    chk("bp_data0",    mem_data,      32'h10000001);
    chk("bp_addr0",    32'(mem_addr), 32'd0);
    set_bundle(2'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h55);
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_data1",    mem_data,      32'h10000002);
    chk("bp_addr1",    32'(mem_addr), 32'd1);
    chk("bp_ready_re", 32'(in_ready), 32'd1);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk("bp_we_k",   32'(mem_we),   32'd1);
      chk("bp_data_k", mem_data,      32'h10000000 | 32'(k + 1));
      chk("bp_addr_k", 32'(mem_addr), 32'(k));
    end
    tick();
    chk("bp_end_we",   32'(mem_we),   32'd0);
    chk("bp_written",  32'(written),  32'd5);
    chk("bp_end_busy", 32'(busy),     32'd0);

    // addr_load while busy is ignored
    mem_ready = 1'b0;
    set_bundle(2'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; addr_load = 1'b1; addr_in = 12'h123;
    tick();
    chk("ld_ign_we",    32'(mem_we),   32'd1);
    chk("ld_ign_addr1", 32'(mem_addr), 32'd5);
    tick();
    chk("ld_ign_addr2", 32'(mem_addr), 32'd5);
    addr_load = 1'b0; mem_ready = 1'b1;
    tick();
    chk("ld_ign_addr3", 32'(mem_addr), 32'd6);
    chk("ld_ign_wr",    32'(written),  32'd6);

    // Load 0xFFF then wrap through zero
    addr_load = 1'b1; addr_in = 12'hFFF;
    tick();
    addr_load = 1'b0;
    chk("wr_load_addr", 32'(mem_addr), 32'hFFF);
    chk("wr_pre_flag",  32'(wrapped),  32'd0);
    mem_ready = 1'b0;
    set_bundle(2'd1, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0);
    in_valid = 1'b1;
    tick();
    set_bundle(2'd3, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    in_valid = 1'b0;
    chk("wr_addr_fff", 32'(mem_addr), 32'hFFF);
    chk("wr_data0",    mem_data,      32'h2841FFFF);
    mem_ready = 1'b1;
    tick();
    chk("wr_addr_000", 32'(mem_addr), 32'h000);
    chk("wr_flag",     32'(wrapped),  32'd1);
    chk("wr_data1",    mem_data,      32'h27C00000);
    tick();
    chk("wr_end_we",   32'(mem_we),   32'd0);
    chk("wr_sticky",   32'(wrapped),  32'd1);
    chk("wr_written",  32'(written),  32'd8);

    // Reset while a write is pending and the FIFO holds another word
    mem_ready = 1'b0;
    set_bundle(2'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("mr_pre_we",   32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_we",       32'(mem_we),   32'd0);
    chk("mr_written",  32'(written),  32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_busy",     32'(busy),     32'd0);
    chk("mr_addr",     32'(mem_addr), 32'd0);
    chk("mr_wrapped",  32'(wrapped),  32'd0);
    #3 reset_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("mr_post_we",      32'(mem_we),  32'd0);
    chk("mr_post_written", 32'(written), 32'd0);
    chk("mr_post_busy",    32'(busy),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
